pwm_duty_ctrl: RTL and testbench
================================

Name: pwm_duty_ctrl

Overview:
- Generates the 4-bit duty word that drives the downstream PWM comparator stage (duty input, 0..15, output high while duty > counter).
- Two raw push-buttons step the duty up or down by one. Each button is synchronized, debounced and edge-detected, and the duty saturates at 0 and 15.
- The duty word is registered and glitch-free, so it connects straight to the PWM duty input.
- Optional auto "breathe" triangle ramp, compiled in by macro.

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles of the synced button before the debounced state flips (min 2).
- DUTY_RESET, 4'd0, duty value loaded on reset.
- RAMP_DIV, 1000000, clk cycles per ramp step in breathe mode (used only with the macro, min 2).

Ports:
- clk  input  1  system clock, all logic on posedge
- rst  input  1  synchronous active-high reset
- btn_up  input  1  raw, asynchronous, bouncing button: increment request
- btn_down  input  1  raw, asynchronous, bouncing button: decrement request
- breathe_en  input  1  level: enable auto ramp (ignored when the macro is undefined)
- duty  output  4  registered duty word to the PWM stage
- at_max  output  1  registered, high when duty == 15
- at_min  output  1  registered, high when duty == 0

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. There are no asynchronous elements.
- Reset values:
  - duty = DUTY_RESET; at_max and at_min reflect DUTY_RESET.
  - Sync flops, debounced states, their delayed copies, debounce counters, ramp prescaler = 0; ramp direction = up.
  - Reset takes priority mid-operation: a partially counted debounce or ramp is discarded.
- Synchronizer: two flops per button. The raw value sampled at edge N is on the second flop after edge N+1.
- Debounce, per button:
  - The counter clears whenever synced == debounced.
  - Otherwise the counter increments. On the edge where it reaches DEBOUNCE_CYCLES-1 and synced still differs, the debounced state flips and the counter clears.
  - A bounce shorter than DEBOUNCE_CYCLES cycles produces no flip.
  - Counter width is clog2(DEBOUNCE_CYCLES). It never wraps.
- Press pulse: debounced & ~debounced_d, one cycle. Release generates nothing.
- Duty update, on the edge after the pulse:
  - up pulse only: duty+1, saturating at 15.
  - down pulse only: duty-1, saturating at 0.
  - Both pulses in the same cycle: no change.
- Latency: raw high first sampled at edge 1 and held → debounced flips at edge DEBOUNCE_CYCLES+2 → duty changes at edge DEBOUNCE_CYCLES+3.
- Holding a button gives exactly one step; there is no auto-repeat.
- at_max and at_min are registered together with duty and are always consistent with it.
- No combinational path from any input to any output.

Optional Feature:
- Macro: PWM_DUTY_CTRL_BREATHE_EN.
- Defined:
  - While breathe_en = 1, a prescaler counts 0..RAMP_DIV-1. On wrap it issues a tick that steps duty ±1 in the current direction.
  - At 15 going up, the next tick gives 14 and the direction becomes down. At 0 going down, the next tick gives 1 and the direction becomes up. Period = 30 ticks.
  - Button pulses are ignored while breathing, but debouncers keep running.
  - On breathe_en 1→0: duty holds its value, the prescaler clears, and direction is retained.
  - On breathe_en 0→1: the ramp resumes from the current duty.
- Undefined: breathe_en is unconnected internally; no prescaler or direction logic is synthesized.

Test Plan:
- Reset with DUTY_RESET=0 and DEBOUNCE_CYCLES=4 → duty=0, at_min=1, at_max=0 on the first post-reset cycle.
- btn_up high from edge 1, held 20 cycles → duty becomes 1 exactly at edge 7; no further change while held; release leaves it at 1.
- btn_up toggled every 2 cycles for 30 cycles (bounce < 4), then low → duty stays 0.
- 16 clean up presses from 0 → duty reaches 15 and at_max=1 after the 15th; the 16th leaves duty=15. 16 down presses → 0, at_min=1.
- btn_up and btn_down asserted on the same edge and held → both pulses coincide; duty unchanged; rst pulsed mid-debounce → duty=DUTY_RESET and no late step.
- With macro, RAMP_DIV=3, duty=13, breathe_en=1 → duty 14, 15, 14, 13 at 3-cycle spacing; btn_up press during ramp has no effect; breathe_en=0 → duty frozen.

Source files
------------

// File: rtl/pwm_duty_ctrl.sv
// Button-driven 4-bit PWM duty register: two-flop sync, debounce, press-edge detect, saturating step.
// Optional triangle "breathe" ramp compiled in with PWM_DUTY_CTRL_BREATHE_EN.
module pwm_duty_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter logic [3:0]  DUTY_RESET      = 4'd0,
  parameter int unsigned RAMP_DIV        = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       breathe_en,
  output logic [3:0] duty,
  output logic       at_max,
  output logic       at_min
);

  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] DUTY_MAX = 4'd15;
  localparam logic [3:0] DUTY_MIN = 4'd0;

  // index 0 = up button, index 1 = down button
  logic [1:0]      btn_raw;
  logic [1:0]      sync1;
  logic [1:0]      sync2;
  logic [1:0]      db;
  logic [1:0]      db_d;
  logic [DB_W-1:0] db_cnt [2];
  logic [1:0]      press_c;
  logic [3:0]      duty_nxt;

  assign btn_raw = {btn_down, btn_up};
  assign press_c = db & ~db_d;

  // Synchronizer, debounce counter and delayed debounced state
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      db_d  <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      db_d  <= db;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db[i]     <= ~db[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

`ifdef PWM_DUTY_CTRL_BREATHE_EN
  localparam int unsigned RD_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [RD_W-1:0] RD_LAST = RD_W'(RAMP_DIV - 1);

  logic [RD_W-1:0] presc;
  logic [RD_W-1:0] presc_nxt;
  logic            dir_up;
  logic            dir_up_nxt;

  // Next duty: button steps, overridden by the ramp while breathing
  always_comb begin
    duty_nxt   = duty;
    presc_nxt  = '0;
    dir_up_nxt = dir_up;
    if (breathe_en) begin
      if (presc == RD_LAST) begin
        if (dir_up) begin
          if (duty == DUTY_MAX) begin
            duty_nxt   = DUTY_MAX - 4'd1;
            dir_up_nxt = 1'b0;
          end else begin
            duty_nxt = duty + 4'd1;
          end
        end else begin
          if (duty == DUTY_MIN) begin
            duty_nxt   = DUTY_MIN + 4'd1;
            dir_up_nxt = 1'b1;
          end else begin
            duty_nxt = duty - 4'd1;
          end
        end
      end else begin
        presc_nxt = presc + RD_W'(1);
      end
    end else begin
      case (press_c)
        2'b01:   if (duty != DUTY_MAX) duty_nxt = duty + 4'd1;
        2'b10:   if (duty != DUTY_MIN) duty_nxt = duty - 4'd1;
        default: duty_nxt = duty;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc  <= '0;
      dir_up <= 1'b1;
    end else begin
      presc  <= presc_nxt;
      dir_up <= dir_up_nxt;
    end
  end
`else
  localparam int unsigned unused_ramp_div = RAMP_DIV;
  logic unused_breathe_en;
  assign unused_breathe_en = breathe_en;

  // Next duty: saturating step on a lone press pulse
  always_comb begin
    duty_nxt = duty;
    case (press_c)
      2'b01:   if (duty != DUTY_MAX) duty_nxt = duty + 4'd1;
      2'b10:   if (duty != DUTY_MIN) duty_nxt = duty - 4'd1;
      default: duty_nxt = duty;
    endcase
  end
`endif

  // Duty and flags registered together so they never disagree
  always_ff @(posedge clk) begin
    if (rst) begin
      duty   <= DUTY_RESET;
      at_max <= (DUTY_RESET == DUTY_MAX);
      at_min <= (DUTY_RESET == DUTY_MIN);
    end else begin
      duty   <= duty_nxt;
      at_max <= (duty_nxt == DUTY_MAX);
      at_min <= (duty_nxt == DUTY_MIN);
    end
  end

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Directed bench for pwm_duty_ctrl; the breathe test follows PWM_DUTY_CTRL_BREATHE_EN.
module tb_pwm_duty_ctrl;

  localparam int unsigned DC = 4;
  localparam int unsigned RD = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_up;
  logic       btn_down;
  logic       breathe_en;
  logic [3:0] duty;
  logic       at_max;
  logic       at_min;

  int tests = 0;
  int fails = 0;

  pwm_duty_ctrl #(
    .DEBOUNCE_CYCLES(DC),
    .DUTY_RESET     (4'd0),
    .RAMP_DIV       (RD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .breathe_en(breathe_en),
    .duty      (duty),
    .at_max    (at_max),
    .at_min    (at_min)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic up, input logic dn);
    btn_up   = up;
    btn_down = dn;
    repeat (DC + 4) tick();
    btn_up   = 1'b0;
    btn_down = 1'b0;
    repeat (DC + 4) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    btn_up = 1'b0;
    btn_down = 1'b0;
    breathe_en = 1'b0;
    repeat (3) tick();
    tests++;
    if (duty !== 4'd0) begin fails++; $display("FAIL reset_duty: got %0d want 0", duty); end
    tests++;
    if (at_min !== 1'b1) begin fails++; $display("FAIL reset_at_min: got %b want 1", at_min); end
    tests++;
    if (at_max !== 1'b0) begin fails++; $display("FAIL reset_at_max: got %b want 0", at_max); end
    rst = 1'b0;
  endtask

  task automatic test_hold();
    logic [3:0] exp;
    btn_up = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      exp = (k >= 7) ? 4'd1 : 4'd0;
      tests++;
      if (duty !== exp) begin
        fails++;
        $display("FAIL hold_edge%0d: got %0d want %0d", k, duty, exp);
      end
    end
    btn_up = 1'b0;
    repeat (12) tick();
    tests++;
    if (duty !== 4'd1) begin fails++; $display("FAIL hold_release: got %0d want 1", duty); end
  endtask

  task automatic test_bounce();
    do_reset();
    for (int k = 0; k < 30; k++) begin
      btn_up = ((k / 2) % 2) == 0;
      tick();
    end
    btn_up = 1'b0;
    repeat (12) tick();
    tests++;
    if (duty !== 4'd0) begin fails++; $display("FAIL bounce: got %0d want 0", duty); end
  endtask

  task automatic test_saturate();
    logic [3:0] exp;
    for (int i = 1; i <= 16; i++) begin
      press(1'b1, 1'b0);
      exp = (i > 15) ? 4'd15 : 4'(i);
      tests++;
      if (duty !== exp || at_max !== (exp == 4'd15) || at_min !== 1'b0) begin
        fails++;
        $display("FAIL sat_up%0d: got duty=%0d max=%b min=%b want duty=%0d", i, duty, at_max, at_min, exp);
      end
    end
    for (int i = 1; i <= 16; i++) begin
      press(1'b0, 1'b1);
      exp = (i >= 15) ? 4'd0 : 4'(15 - i);
      tests++;
      if (duty !== exp || at_min !== (exp == 4'd0) || at_max !== 1'b0) begin
        fails++;
        $display("FAIL sat_dn%0d: got duty=%0d max=%b min=%b want duty=%0d", i, duty, at_max, at_min, exp);
      end
    end
  endtask

  task automatic test_both_and_reset();
    repeat (3) press(1'b1, 1'b0);
    tests++;
    if (duty !== 4'd3) begin fails++; $display("FAIL both_setup: got %0d want 3", duty); end
    btn_up   = 1'b1;
    btn_down = 1'b1;
    repeat (12) tick();
    tests++;
    if (duty !== 4'd3) begin fails++; $display("FAIL both_held: got %0d want 3", duty); end
    btn_up   = 1'b0;
    btn_down = 1'b0;
    repeat (12) tick();
    tests++;
    if (duty !== 4'd3) begin fails++; $display("FAIL both_release: got %0d want 3", duty); end
    // partially debounced press, then reset with the button released
    btn_up = 1'b1;
    repeat (4) tick();
    btn_up = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if (duty !== 4'd0 || at_min !== 1'b1) begin
      fails++;
      $display("FAIL mid_reset: got duty=%0d min=%b want 0/1", duty, at_min);
    end
    repeat (12) tick();
    tests++;
    if (duty !== 4'd0) begin fails++; $display("FAIL no_late_step: got %0d want 0", duty); end
  endtask

  task automatic test_breathe();
    logic [3:0] exp;
    logic       up;
    int         pc;
    do_reset();
    repeat (13) press(1'b1, 1'b0);
    tests++;
    if (duty !== 4'd13) begin fails++; $display("FAIL breathe_setup: got %0d want 13", duty); end
    exp = 4'd13;
`ifdef PWM_DUTY_CTRL_BREATHE_EN
    up = 1'b1;
    pc = 0;
    breathe_en = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      btn_up = (k <= 10);
      tick();
      if (pc == int'(RD) - 1) begin
        pc = 0;
        if (up) begin
          if (exp == 4'd15) begin exp = 4'd14; up = 1'b0; end
          else exp = exp + 4'd1;
        end else begin
          if (exp == 4'd0) begin exp = 4'd1; up = 1'b1; end
          else exp = exp - 4'd1;
        end
      end else begin
        pc++;
      end
      tests++;
      if (duty !== exp || at_max !== (exp == 4'd15)) begin
        fails++;
        $display("FAIL ramp_edge%0d: got duty=%0d max=%b want %0d", k, duty, at_max, exp);
      end
    end
`else
    up = 1'b0;
    pc = 0;
    breathe_en = 1'b1;
    repeat (12) tick();
    tests++;
    if (duty !== exp) begin fails++; $display("FAIL breathe_ignored: got %0d want %0d", duty, exp); end
`endif
    breathe_en = 1'b0;
    btn_up = 1'b0;
    repeat (10) tick();
    tests++;
    if (duty !== exp) begin
      fails++;
      $display("FAIL breathe_frozen: got %0d want %0d (dir %b pc %0d)", duty, exp, up, pc);
    end
  endtask

  initial begin
    test_reset();
    test_hold();
    test_bounce();
    test_saturate();
    test_both_and_reset();
    test_breathe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
